alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Issue controller for the 8-bit ALU units (add8, sub8, comparator, bwand8/bwor8/bwxor8, shifter).
//  Takes one op per start pulse, latches operands, and enables exactly one unit on the shared operand/result buses.
//  Captures result and flags into its own registers; iterates the shifter for multi-bit shifts.
//  Sits between the instruction decoder and the ALU units.
// PARAMETERS
//  SHAMT_W   3   width of shift amount, taken from b_in[SHAMT_W-1:0] (max shift 2^SHAMT_W-1)
//  TRAP_ILL  1   1: illegal opcode sets err with done; 0: illegal opcode is a silent NOP with done
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  op request; sampled only in IDLE
//  opcode     in   4  0 ADD,1 SUB,2 CMP,3 AND,4 OR,5 XOR,6 SHL,7 SHR,8-15 illegal
//  a_in,b_in  in   8  operands; latched on start acceptance
//  op_a,op_b  out  8  latched operands driven to unit inputs
//  unit_en    out  7  one-hot {shf,xor,or,and,cmp,sub,add} enables
//  shf_d      out  8  shifter d_in: op_a on load, shifted q on each step
//  shftd_en   out  2  shifter shftd_out_en: 01 SHR, 10 SHL, 00 otherwise
//  res_bus    in   8  shared unit result bus (s_out/d_out/c_out/q_out)
//  flg_bus    in   5  shared {C,Z,N,V,S}; CMP eq arrives on Z; shifted_l/r arrive on C
//  busy       out  1  high from acceptance until done
//  done       out  1  one-cycle pulse, result/flags valid
//  err        out  1  set with done on illegal opcode (TRAP_ILL=1); cleared on next acceptance
//  result     out  8  registered result
//  flags      out  5  registered {C,Z,N,V,S}
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy,done,err=0; unit_en=0; shftd_en=00; shf_d=0; op_a,op_b=0; result=0; flags=0.
//  States: IDLE -> EXEC -> DONE -> IDLE (ALU ops); IDLE -> LOAD -> SHIFT* -> DONE -> IDLE (shifts); IDLE -> DONE (illegal).
//  IDLE: start=1 -> latch a/b/opcode, busy=1; go EXEC (0-5), LOAD (6,7), or DONE (8-15).
//  EXEC: the one matching unit_en bit is high for exactly 1 cycle; units settle combinationally.
//   At the end of the cycle, capture res_bus to result; go DONE.
//  Flag update per op:
//   ADD/SUB: all five flags written.
//   CMP: Z only; result unchanged.
//   AND/OR/XOR: Z,N written; C,V,S held.
//  LOAD: shf_en=1, shf_d=op_a; shifter register loads on this edge. Counter cnt=b[SHAMT_W-1:0].
//   cnt=0 -> DONE with result=op_a, C=0, Z/N from op_a.
//  SHIFT: each cycle shf_d=q<<1 (SHL) or q>>1 (SHR), zero fill; shftd_en selects the outgoing bit.
//   Outgoing bit is captured to C; cnt decrements. Leave after cnt reaches 0; result=q, Z/N from flg_bus. V,S held.
//  DONE: done=1 for 1 cycle, busy=0 in the same cycle, unit_en=0; return to IDLE.
//  Latency, start acceptance to done: ALU ops 2 cycles; shifts 2+cnt cycles; illegal 1 cycle.
//  Throughput: start is ignored while busy or in DONE; the earliest new acceptance is the cycle after done.
//  No two unit_en bits are ever high together. Tristated buses are never driven by two units at once.
//  Reset mid-operation: unit_en, shftd_en drop immediately; op is abandoned; no done.
//  Illegal op: result and flags unchanged; err=TRAP_ILL.
// TESTING
//  Reset mid-SHIFT (cnt=5, rst_n low after 2 steps) -> unit_en=0 at once, busy=0, no done; next op runs normally.
//  ADD a=0x7F b=0x01 -> done 2 cycles after start: result=0x80, flags C0 Z0 N1 V1 S0; only unit_en[0] ever high.
//  SUB a=0x05 b=0x05 -> result=0x00, Z=1, C=0; then CMP a=0x12 b=0x34 -> Z=0, C/N/V/S held from SUB.
//  SHL a=0x81 b=3 -> done at cycle 5, result=0x08, C=0 (last bit out); SHR a=0x01 b=1 -> result=0x00, C=1, Z=1.
//  Shift by 0 and opcode 0xB -> immediate completion, correct err, result unchanged for illegal.
//  start held high continuously -> ops accepted back-to-back only in IDLE; second op's operands taken on re-entry.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bundle between the ALU issue controller, the decoder side and the ALU units.
// slave = sequencer view, master = decoder/unit environment view.
interface alu_sequencer_if;
    logic       start;
    logic [3:0] opcode;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [6:0] unit_en;
    logic [7:0] shf_d;
    logic [1:0] shftd_en;
    logic [7:0] res_bus;
    logic [4:0] flg_bus;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [4:0] flags;

    modport slave (
        input  start, opcode, a_in, b_in,
        input  res_bus, flg_bus,
        output op_a, op_b, unit_en, shf_d, shftd_en,
        output busy, done, err, result, flags
    );

    modport master (
        output start, opcode, a_in, b_in,
        output res_bus, flg_bus,
        input  op_a, op_b, unit_en, shf_d, shftd_en,
        input  busy, done, err, result, flags
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue controller for the 8-bit ALU units: one op per start pulse,
// one unit enabled at a time, iterative shifts, registered result/flags.
module alu_sequencer #(
    parameter int unsigned SHAMT_W  = 3,
    parameter bit          TRAP_ILL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave sq
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

    localparam int FC = 4;
    localparam int FZ = 3;
    localparam int FN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         opc_q, opc_d;
    logic [7:0]         op_a_q, op_a_d;
    logic [7:0]         op_b_q, op_b_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [7:0]         result_q, result_d;
    logic [4:0]         flags_q, flags_d;
    logic               err_q, err_d;

    logic [6:0] unit_sel;
    logic [6:0] unit_en;
    logic [7:0] shf_d;
    logic [7:0] shf_next;
    logic [1:0] shftd_en;
    logic       busy;
    logic       done;
    logic       is_shl;

    always_comb begin
        unit_sel = '0;
        unique case (1'b1)
            (opc_q == OP_ADD): unit_sel = 7'b000_0001;
            (opc_q == OP_SUB): unit_sel = 7'b000_0010;
            (opc_q == OP_CMP): unit_sel = 7'b000_0100;
            (opc_q == OP_AND): unit_sel = 7'b000_1000;
            (opc_q == OP_OR):  unit_sel = 7'b001_0000;
            (opc_q == OP_XOR): unit_sel = 7'b010_0000;
            (opc_q == OP_SHL),
            (opc_q == OP_SHR): unit_sel = 7'b100_0000;
            default:           unit_sel = '0;
        endcase
    end

    assign is_shl = (opc_q == OP_SHL);

    // The shifter's q comes back on res_bus while it is enabled.
    assign shf_next = is_shl ? {sq.res_bus[6:0], 1'b0}
                             : {1'b0, sq.res_bus[7:1]};

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        unit_en  = '0;
        shf_d    = '0;
        shftd_en = 2'b00;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sq.start) begin
                    opc_d  = sq.opcode;
                    op_a_d = sq.a_in;
                    op_b_d = sq.b_in;
                    cnt_d  = sq.b_in[SHAMT_W-1:0];
                    err_d  = 1'b0;
                    if (sq.opcode < OP_SHL) begin
                        state_d = S_EXEC;
                    end else if (sq.opcode <= OP_SHR) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                        err_d   = TRAP_ILL;
                    end
                end
            end

            S_EXEC: begin
                busy    = 1'b1;
                unit_en = unit_sel;
                state_d = S_DONE;
                unique case (1'b1)
                    (opc_q == OP_ADD),
                    (opc_q == OP_SUB): begin
                        result_d = sq.res_bus;
                        flags_d  = sq.flg_bus;
                    end
                    (opc_q == OP_CMP): begin
                        flags_d[FZ] = sq.flg_bus[FZ];
                    end
                    (opc_q == OP_AND),
                    (opc_q == OP_OR),
                    (opc_q == OP_XOR): begin
                        result_d    = sq.res_bus;
                        flags_d[FZ] = sq.flg_bus[FZ];
                        flags_d[FN] = sq.flg_bus[FN];
                    end
                    default: ;
                endcase
            end

            S_LOAD: begin
                busy    = 1'b1;
                unit_en = unit_sel;
                shf_d   = op_a_q;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    result_d    = op_a_q;
                    flags_d[FC] = 1'b0;
                    flags_d[FZ] = (op_a_q == 8'h00);
                    flags_d[FN] = op_a_q[7];
                end else begin
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                busy        = 1'b1;
                unit_en     = unit_sel;
                shf_d       = shf_next;
                shftd_en    = is_shl ? 2'b10 : 2'b01;
                flags_d[FC] = sq.flg_bus[FC];
                cnt_d       = cnt_q - SHAMT_W'(1);
                // Z/N describe the value the shifter holds after this step.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d     = S_DONE;
                    result_d    = shf_next;
                    flags_d[FZ] = (shf_next == 8'h00);
                    flags_d[FN] = shf_next[7];
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign sq.op_a     = op_a_q;
    assign sq.op_b     = op_b_q;
    assign sq.unit_en  = unit_en;
    assign sq.shf_d    = shf_d;
    assign sq.shftd_en = shftd_en;
    assign sq.busy     = busy;
    assign sq.done     = done;
    assign sq.err      = err_q;
    assign sq.result   = result_q;
    assign sq.flags    = flags_q;

`ifndef SYNTHESIS
    a_unit_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(unit_en));
    a_shftd_legal: assert property (
        @(posedge clk) disable iff (!rst_n) shftd_en != 2'b11);
    a_done_idle: assert property (
        @(posedge clk) disable iff (!rst_n) done |-> (!busy && unit_en == '0));
`endif

endmodule
